// File: rtl/ni_pkg.sv
// Shared types and defaults for the PE-side network interface.
// Holds the tx FSM state type and the FIFO occupancy-width helper.
package ni_pkg;

    localparam int PKT_W_DEFAULT = 64;
    localparam int CNT_W_DEFAULT = 16;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    // Occupancy needs one bit more than the address so "full" is representable.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pe_net_interface_if.sv
// Handshake bundle between the network interface, its PE and the router PE port.
// slave is the network-interface side; master is whatever drives it (PE + router).
interface pe_net_interface_if
    import ni_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             pe_tx_valid;
    logic [PKT_W-1:0] pe_tx_data;
    logic             pe_tx_ready;
    logic             net_si;
    logic [PKT_W-1:0] net_packet_out;
    logic             net_ri;
    logic             net_so;
    logic [PKT_W-1:0] net_packet_in;
    logic             net_ro;
    logic             pe_rx_valid;
    logic [PKT_W-1:0] pe_rx_data;
    logic             pe_rx_ready;
    logic             clear_cnt;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;

    modport master (
        output pe_tx_valid, pe_tx_data, net_ri, net_so, net_packet_in,
               pe_rx_ready, clear_cnt,
        input  pe_tx_ready, net_si, net_packet_out, net_ro, pe_rx_valid,
               pe_rx_data, tx_count, rx_count
    );

    modport slave (
        input  pe_tx_valid, pe_tx_data, net_ri, net_so, net_packet_in,
               pe_rx_ready, clear_cnt,
        output pe_tx_ready, net_si, net_packet_out, net_ro, pe_rx_valid,
               pe_rx_data, tx_count, rx_count
    );

endinterface

// File: rtl/ni_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pushes while full and pops while
// empty are dropped, storage is not reset (only pointers and occupancy).
module ni_sync_fifo
    import ni_pkg::*;
#(
    parameter int WIDTH = PKT_W_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic                         rd_en,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [fifo_cnt_w(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    level;
    logic             push;
    logic             pop;

    // Push is gated on the registered full flag, so a pop in the same cycle
    // never opens a slot for a write that arrived while full.
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;
    assign dout  = mem[rd_ptr];
    assign count = level;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pe_net_interface.sv
// PE-side network interface: tx FIFO + output register toward the router,
// rx FIFO toward the PE, and wrapping delivered/accepted packet counters.
module pe_net_interface
    import ni_pkg::*;
#(
    parameter int PKT_W    = PKT_W_DEFAULT,
    parameter int TX_DEPTH = DEPTH_DEFAULT,
    parameter int RX_DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W    = CNT_W_DEFAULT
) (
    input logic               clk,
    input logic               reset,
    pe_net_interface_if.slave bus
);

    localparam int TX_CW = fifo_cnt_w(TX_DEPTH);
    localparam int RX_CW = fifo_cnt_w(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_MAX = TX_CW'(TX_DEPTH);
    localparam logic [RX_CW-1:0] RX_MAX = RX_CW'(RX_DEPTH);

    tx_state_t        tx_state;
    tx_state_t        tx_state_nxt;
    logic             tx_pop;
    logic             tx_empty;
    logic             tx_full;
    logic [TX_CW-1:0] tx_level;
    logic [PKT_W-1:0] tx_head;
    logic [PKT_W-1:0] pkt_out_p1;
    logic             delivered;

    logic             rx_empty;
    logic             rx_full;
    logic [RX_CW-1:0] rx_level;
    logic [PKT_W-1:0] rx_head;
    logic             rx_accept;

    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;

    ni_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (bus.pe_tx_valid),
        .rd_en (tx_pop),
        .din   (bus.pe_tx_data),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_level)
    );

    ni_sync_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr_en (bus.net_so),
        .rd_en (bus.pe_rx_ready),
        .din   (bus.net_packet_in),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_level)
    );

    // Tx FSM: SEND owns the output register; a delivery with more data
    // waiting reloads it in the same edge so net_si never drops between packets.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop       = 1'b1;
                    tx_state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (bus.net_ri) begin
                    tx_pop       = !tx_empty;
                    tx_state_nxt = tx_empty ? TX_IDLE : TX_SEND;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_nxt;
    end

    // Output register stage (p1): the packet currently offered to the router.
    always_ff @(posedge clk) begin
        if (!reset)      pkt_out_p1 <= '0;
        else if (tx_pop) pkt_out_p1 <= tx_head;
    end

    assign delivered = (tx_state == TX_SEND) && bus.net_ri;
    assign rx_accept = bus.net_so && !rx_full;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else if (bus.clear_cnt) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (delivered) tx_cnt <= tx_cnt + 1'b1;
            if (rx_accept) rx_cnt <= rx_cnt + 1'b1;
        end
    end

    assign bus.pe_tx_ready    = !tx_full;
    assign bus.net_si         = (tx_state == TX_SEND);
    assign bus.net_packet_out = pkt_out_p1;
    assign bus.net_ro         = !rx_full;
    assign bus.pe_rx_valid    = !rx_empty;
    assign bus.pe_rx_data     = rx_head;
    assign bus.tx_count       = tx_cnt;
    assign bus.rx_count       = rx_cnt;

    a_tx_level: assert property (@(posedge clk) disable iff (!reset) tx_level <= TX_MAX);
    a_rx_level: assert property (@(posedge clk) disable iff (!reset) rx_level <= RX_MAX);

endmodule

// File: tb/tb_pe_net_interface.sv
// Bench for pe_net_interface: directed scenarios plus a random phase, checked
// each cycle against a packet-queue model of the tx and rx paths.
module tb_pe_net_interface;

    localparam int PKT_W    = 64;
    localparam int TX_DEPTH = 4;
    localparam int RX_DEPTH = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_MOD  = 1 << CNT_W;

    logic clk;
    logic reset;

    pe_net_interface_if #(.PKT_W(PKT_W), .CNT_W(CNT_W)) bus ();

    pe_net_interface #(
        .PKT_W    (PKT_W),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: every packet inside the interface in order; 'presented' means the
    // oldest one is sitting in front of the router.
    logic [63:0] txq[$];
    bit          presented;
    logic [63:0] rxq[$];
    int          m_tx_cnt;
    int          m_rx_cnt;
    bit          last_tx_acc;
    bit          last_rx_acc;
    logic [63:0] tx_sent[$];
    logic [63:0] rx_sent[$];
    logic [63:0] dut_tx_out[$];
    logic [63:0] dut_rx_out[$];
    int          dut_tx_cyc[$];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int tx_fifo_n();
        return txq.size() - (presented ? 1 : 0);
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        presented   = 1'b0;
        m_tx_cnt    = 0;
        m_rx_cnt    = 0;
        last_tx_acc = 1'b0;
        last_rx_acc = 1'b0;
    endtask

    task automatic check_outputs();
        chk("pe_tx_ready", 64'(bus.pe_tx_ready), 64'(tx_fifo_n() < TX_DEPTH));
        chk("net_si", 64'(bus.net_si), 64'(presented));
        if (presented) chk("net_packet_out", bus.net_packet_out, txq[0]);
        chk("net_ro", 64'(bus.net_ro), 64'(rxq.size() < RX_DEPTH));
        chk("pe_rx_valid", 64'(bus.pe_rx_valid), 64'(rxq.size() > 0));
        if (rxq.size() > 0) chk("pe_rx_data", bus.pe_rx_data, rxq[0]);
        chk("tx_count", 64'(bus.tx_count), 64'(m_tx_cnt));
        chk("rx_count", 64'(bus.rx_count), 64'(m_rx_cnt));
    endtask

    task automatic model_edge(input bit rst_n, input bit tv, input logic [63:0] td,
                              input bit ri, input bit so, input logic [63:0] pin,
                              input bit rr, input bit clr);
        int n_fifo;
        bit dlv;
        bit rx_pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        n_fifo      = tx_fifo_n();
        last_tx_acc = tv && (n_fifo < TX_DEPTH);
        dlv         = presented && ri;
        last_rx_acc = so && (rxq.size() < RX_DEPTH);
        rx_pop      = rr && (rxq.size() > 0);
        if (dlv) void'(txq.pop_front());
        if (dlv || !presented) presented = (n_fifo > 0);
        if (last_tx_acc) begin
            txq.push_back(td);
            tx_sent.push_back(td);
        end
        if (rx_pop) void'(rxq.pop_front());
        if (last_rx_acc) begin
            rxq.push_back(pin);
            rx_sent.push_back(pin);
        end
        if (clr) begin
            m_tx_cnt = 0;
            m_rx_cnt = 0;
        end else begin
            if (dlv)         m_tx_cnt = (m_tx_cnt + 1) % CNT_MOD;
            if (last_rx_acc) m_rx_cnt = (m_rx_cnt + 1) % CNT_MOD;
        end
    endtask

    // Inputs are driven 1 ns after an edge; outputs are checked 2 ns after it.
    task automatic tick();
        bit rst_n, tv, ri, so, rr, clr;
        logic [63:0] td, pin;
        #1;
        check_outputs();
        rst_n = reset;
        tv = bus.pe_tx_valid;  td  = bus.pe_tx_data;
        ri = bus.net_ri;       so  = bus.net_so;
        pin = bus.net_packet_in;
        rr = bus.pe_rx_ready;  clr = bus.clear_cnt;
        if (rst_n && bus.net_si && ri) begin
            dut_tx_out.push_back(bus.net_packet_out);
            dut_tx_cyc.push_back(cyc);
        end
        if (rst_n && bus.pe_rx_valid && rr) dut_rx_out.push_back(bus.pe_rx_data);
        @(posedge clk);
        model_edge(rst_n, tv, td, ri, so, pin, rr, clr);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.pe_tx_valid   = 1'b0;
        bus.pe_tx_data    = '0;
        bus.net_ri        = 1'b0;
        bus.net_so        = 1'b0;
        bus.net_packet_in = 'x;
        bus.pe_rx_ready   = 1'b0;
        bus.clear_cnt     = 1'b0;
    endtask

    task automatic clear_counters();
        bus.clear_cnt = 1'b1;
        tick();
        bus.clear_cnt = 1'b0;
    endtask

    logic [63:0] tx_vals [20];
    logic [63:0] rx_vals [20];
    int idx, xi, acc, tb0, rb0, sb0, rsb0;
    bit seen_si, seen_rv;

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        chk("rst_net_si", 64'(bus.net_si), 64'd0);
        chk("rst_pkt_out", bus.net_packet_out, 64'd0);
        chk("rst_tx_ready", 64'(bus.pe_tx_ready), 64'd1);
        chk("rst_net_ro", 64'(bus.net_ro), 64'd1);
        chk("rst_rx_valid", 64'(bus.pe_rx_valid), 64'd0);
        chk("rst_counts", 64'({bus.tx_count, bus.rx_count}), 64'd0);
        reset = 1'b1;
        tick();

        // Single tx packet: accept at edge N, net_si high for exactly one cycle after N+1.
        bus.net_ri      = 1'b1;
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_data  = 64'hDEAD_BEEF_0000_0001;
        tick();
        bus.pe_tx_valid = 1'b0;
        chk("t1_si_n1", 64'(bus.net_si), 64'd0);
        tick();
        chk("t1_si_n2", 64'(bus.net_si), 64'd1);
        chk("t1_data", bus.net_packet_out, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("t1_si_drop", 64'(bus.net_si), 64'd0);
        chk("t1_tx_count", 64'(bus.tx_count), 64'd1);

        // Tx backpressure: 5 accepted with the router stalled.
        clear_counters();
        bus.net_ri = 1'b0;
        tb0 = dut_tx_out.size();
        idx = 1;
        acc = 0;
        repeat (8) begin
            bus.pe_tx_valid = (idx <= 6);
            bus.pe_tx_data  = 64'(idx);
            tick();
            if (last_tx_acc) begin
                idx++;
                acc++;
            end
        end
        chk("t2_accepts", 64'(acc), 64'd5);
        chk("t2_tx_ready", 64'(bus.pe_tx_ready), 64'd0);
        chk("t2_si_held", 64'(bus.net_si), 64'd1);
        chk("t2_pkt1_held", bus.net_packet_out, 64'd1);
        bus.net_ri = 1'b1;
        repeat (10) begin
            bus.pe_tx_valid = (idx <= 6);
            bus.pe_tx_data  = 64'(idx);
            tick();
            if (last_tx_acc) idx++;
        end
        bus.pe_tx_valid = 1'b0;
        chk("t2_n_delivered", 64'(dut_tx_out.size() - tb0), 64'd6);
        for (int k = 0; k < 6; k++)
            if (tb0 + k < dut_tx_out.size()) chk("t2_order", dut_tx_out[tb0 + k], 64'(k + 1));
        if (tb0 + 4 < dut_tx_cyc.size())
            chk("t2_back_to_back", 64'(dut_tx_cyc[tb0 + 4] - dut_tx_cyc[tb0]), 64'd4);
        chk("t2_tx_count", 64'(bus.tx_count), 64'd6);

        // Rx fill to full with the PE stalled, then drain.
        clear_counters();
        rb0 = dut_rx_out.size();
        idx = 0;
        acc = 0;
        repeat (7) begin
            bus.net_so        = (idx <= 4);
            bus.net_packet_in = 64'hA0 + 64'(idx);
            tick();
            if (last_rx_acc) begin
                idx++;
                acc++;
            end
        end
        chk("t3_accepts", 64'(acc), 64'd4);
        chk("t3_ro_low", 64'(bus.net_ro), 64'd0);
        chk("t3_rx_count", 64'(bus.rx_count), 64'd4);
        bus.pe_rx_ready = 1'b1;
        repeat (8) begin
            bus.net_so        = (idx <= 4);
            bus.net_packet_in = (idx <= 4) ? 64'hA0 + 64'(idx) : 'x;
            tick();
            if (last_rx_acc) idx++;
        end
        bus.net_so = 1'b0;
        bus.net_packet_in = 'x;
        chk("t3_n_consumed", 64'(dut_rx_out.size() - rb0), 64'd5);
        for (int k = 0; k < 5; k++)
            if (rb0 + k < dut_rx_out.size()) chk("t3_order", dut_rx_out[rb0 + k], 64'hA0 + 64'(k));
        chk("t3_rx_count5", 64'(bus.rx_count), 64'd5);

        // Full-rate simultaneous traffic.
        clear_counters();
        for (int k = 0; k < 20; k++) begin
            tx_vals[k] = {$urandom, $urandom};
            rx_vals[k] = {$urandom, $urandom};
        end
        tb0 = dut_tx_out.size();
        rb0 = dut_rx_out.size();
        idx = 0;
        xi  = 0;
        bus.net_ri = 1'b1;
        bus.pe_rx_ready = 1'b1;
        repeat (30) begin
            bus.pe_tx_valid   = (idx < 20);
            bus.pe_tx_data    = (idx < 20) ? tx_vals[idx] : '0;
            bus.net_so        = (xi < 20);
            bus.net_packet_in = (xi < 20) ? rx_vals[xi] : 'x;
            tick();
            if (last_tx_acc) idx++;
            if (last_rx_acc) xi++;
        end
        idle_inputs();
        bus.net_ri = 1'b1;
        bus.pe_rx_ready = 1'b1;
        repeat (4) tick();
        chk("t4_tx_n", 64'(dut_tx_out.size() - tb0), 64'd20);
        chk("t4_rx_n", 64'(dut_rx_out.size() - rb0), 64'd20);
        for (int k = 0; k < 20; k++) begin
            if (tb0 + k < dut_tx_out.size()) chk("t4_tx_data", dut_tx_out[tb0 + k], tx_vals[k]);
            if (rb0 + k < dut_rx_out.size()) chk("t4_rx_data", dut_rx_out[rb0 + k], rx_vals[k]);
        end
        chk("t4_tx_count", 64'(bus.tx_count), 64'(20 % CNT_MOD));
        chk("t4_rx_count", 64'(bus.rx_count), 64'(20 % CNT_MOD));

        // Counter wrap and clear-beats-increment.
        clear_counters();
        idx = 0;
        repeat (30) begin
            bus.pe_tx_valid = (idx < 17);
            bus.pe_tx_data  = {$urandom, $urandom};
            tick();
            if (last_tx_acc) idx++;
        end
        bus.pe_tx_valid = 1'b0;
        repeat (3) tick();
        chk("t5_wrap", 64'(bus.tx_count), 64'd1);
        bus.pe_tx_valid = 1'b1;
        bus.pe_tx_data  = 64'h5555_AAAA_0F0F_F0F0;
        tick();
        bus.pe_tx_valid = 1'b0;
        tick();
        chk("t5_si_before_clr", 64'(bus.net_si), 64'd1);
        bus.clear_cnt = 1'b1;
        tick();
        bus.clear_cnt = 1'b0;
        chk("t5_clear_wins", 64'(bus.tx_count), 64'd0);
        chk("t5_last_pkt", dut_tx_out[$], 64'h5555_AAAA_0F0F_F0F0);

        // Reset in the middle of traffic with packets buffered on both paths.
        clear_counters();
        idle_inputs();
        idx = 0;
        xi  = 0;
        repeat (6) begin
            bus.pe_tx_valid   = (idx < 4);
            bus.pe_tx_data    = {$urandom, $urandom};
            bus.net_so        = (xi < 2);
            bus.net_packet_in = {$urandom, $urandom};
            tick();
            if (last_tx_acc) idx++;
            if (last_rx_acc) xi++;
        end
        idle_inputs();
        chk("t6_in_send", 64'(bus.net_si), 64'd1);
        chk("t6_rx_buffered", 64'(bus.pe_rx_valid), 64'd1);
        reset = 1'b0;
        bus.net_ri = 1'b1;
        tick();
        chk("t6_si", 64'(bus.net_si), 64'd0);
        chk("t6_rx_valid", 64'(bus.pe_rx_valid), 64'd0);
        chk("t6_counts", 64'({bus.tx_count, bus.rx_count}), 64'd0);
        chk("t6_ro", 64'(bus.net_ro), 64'd1);
        chk("t6_tx_ready", 64'(bus.pe_tx_ready), 64'd1);
        reset = 1'b1;
        bus.pe_rx_ready = 1'b1;
        seen_si = 1'b0;
        seen_rv = 1'b0;
        repeat (8) begin
            tick();
            seen_si |= bus.net_si;
            seen_rv |= bus.pe_rx_valid;
        end
        chk("t6_no_stale_tx", 64'(seen_si), 64'd0);
        chk("t6_no_stale_rx", 64'(seen_rv), 64'd0);

        // Random traffic with random stalls and occasional counter clears.
        tb0  = dut_tx_out.size();
        rb0  = dut_rx_out.size();
        sb0  = tx_sent.size();
        rsb0 = rx_sent.size();
        repeat (400) begin
            bus.pe_tx_valid   = $urandom_range(0, 1);
            bus.pe_tx_data    = {$urandom, $urandom};
            bus.net_ri        = ($urandom_range(0, 3) != 0);
            bus.net_so        = $urandom_range(0, 1);
            bus.net_packet_in = bus.net_so ? {$urandom, $urandom} : 'x;
            bus.pe_rx_ready   = ($urandom_range(0, 3) != 0);
            bus.clear_cnt     = ($urandom_range(0, 31) == 0);
            tick();
        end
        idle_inputs();
        bus.net_ri = 1'b1;
        bus.pe_rx_ready = 1'b1;
        repeat (15) tick();
        chk("rnd_tx_n", 64'(dut_tx_out.size() - tb0), 64'(tx_sent.size() - sb0));
        chk("rnd_rx_n", 64'(dut_rx_out.size() - rb0), 64'(rx_sent.size() - rsb0));
        for (int k = 0; tb0 + k < dut_tx_out.size() && sb0 + k < tx_sent.size(); k++)
            chk("rnd_tx_data", dut_tx_out[tb0 + k], tx_sent[sb0 + k]);
        for (int k = 0; rb0 + k < dut_rx_out.size() && rsb0 + k < rx_sent.size(); k++)
            chk("rnd_rx_data", dut_rx_out[rb0 + k], rx_sent[rsb0 + k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
